// File: rtl/univ_ff_pkg.sv
// Shared mode encodings for the universal flip-flop bank.
package univ_ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

endpackage

// File: rtl/ff_cell.sv
// One channel of the bank: combinational next state and illegal-SR flag.
// Zero latency, no backpressure; the caller owns the register.
module ff_cell
  import univ_ff_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_nxt,
  output logic       illegal
);

  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    case (mode_t'(mode))
      MODE_SR: begin
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          // S=R=1 leaves q untouched; it is reported, never propagated.
          2'b11:   illegal = 1'b1;
          default: q_nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      MODE_D:  q_nxt = a;
      MODE_T:  q_nxt = q ^ a;
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky SR error flags and a
// saturating change counter; one-edge latency, no backpressure.
module univ_ff_bank
  import univ_ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err,
  output logic             err_any,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] illegal;
  logic             changed;
  logic             cnt_sat;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .q_nxt   (q_nxt[i]),
      .illegal (illegal[i])
    );
  end

  assign changed = (q_nxt != q);
  assign cnt_sat = (chg_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      err     <= '0;
      chg_cnt <= '0;
    end else begin
      if (en) begin
        q <= q_nxt;
        if (changed && !cnt_sat) chg_cnt <= chg_cnt + CNT_W'(1);
      end
      // A fresh illegal SR input wins over a same-edge clear.
      err <= (clr_err ? '0 : err) | (en ? illegal : '0);
    end
  end

  assign qb      = ~q;
  assign err_any = |err;

endmodule

// File: tb/tb_univ_ff_bank.sv
// Scoreboard bench for univ_ff_bank: a behavioural model predicts each edge,
// and a second instance with CNT_W=2 exercises counter saturation.
module tb_univ_ff_bank;
  import univ_ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q, qb, err, q2, qb2, err2;
  logic       err_any, err_any2;
  logic [7:0] chg_cnt;
  logic [1:0] chg_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] m_q, m_err, m_cnt;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  univ_ff_bank #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q), .qb(qb), .err(err), .err_any(err_any), .chg_cnt(chg_cnt)
  );

  univ_ff_bank #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q2), .qb(qb2), .err(err2), .err_any(err_any2), .chg_cnt(chg_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one channel, written from the truth tables.
  function automatic logic ref_bit(input logic [1:0] m, input logic s, input logic r,
                                   input logic cur);
    if (m == MODE_D) return s;
    if (m == MODE_T) return s ? !cur : cur;
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (s && r && m == MODE_JK) return !cur;
    return cur;
  endfunction

  task automatic step(input logic r, input logic e, input logic c, input logic [1:0] m,
                      input logic [7:0] av, input logic [7:0] bv);
    exp_t       ex, got;
    logic [7:0] nq, ill, exp_qb;
    @(negedge clk);
    rst = r; en = e; clr_err = c; mode = m; a = av; b = bv;
    for (int i = 0; i < 8; i++) begin
      nq[i]  = ref_bit(m, av[i], bv[i], m_q[i]);
      ill[i] = (m == MODE_SR) && av[i] && bv[i];
    end
    if (r) begin
      m_q = '0; m_err = '0; m_cnt = '0; m_cnt2 = '0;
    end else begin
      if (e) begin
        if (nq != m_q) begin
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        m_q = nq;
      end
      m_err = (c ? 8'h00 : m_err) | (e ? ill : 8'h00);
    end
    ex.q = m_q; ex.err = m_err; ex.cnt = m_cnt; ex.cnt2 = m_cnt2;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got    = sb_q.pop_front();
      exp_qb = ~got.q;
      chk("q", {24'b0, q}, {24'b0, got.q});
      chk("qb", {24'b0, qb}, {24'b0, exp_qb});
      chk("err", {24'b0, err}, {24'b0, got.err});
      chk("err_any", {31'b0, err_any}, {31'b0, |got.err});
      chk("chg_cnt", {24'b0, chg_cnt}, {24'b0, got.cnt});
      chk("q_sat", {24'b0, q2}, {24'b0, got.q});
      chk("chg_cnt_sat", {30'b0, chg_cnt2}, {30'b0, got.cnt2});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr_err = 1'b0; mode = MODE_D; a = 8'hFF; b = 8'hFF;
    m_q = '0; m_err = '0; m_cnt = '0; m_cnt2 = '0;

    // Reset with D-mode all-ones inputs held on the data pins.
    step(1, 1, 0, MODE_D, 8'hFF, 8'hFF);
    step(1, 1, 0, MODE_D, 8'hFF, 8'hFF);
    chk("rst_q", {24'b0, q}, 32'h00);
    chk("rst_qb", {24'b0, qb}, 32'hFF);
    chk("rst_cnt", {24'b0, chg_cnt}, 32'd0);

    // SR sweep on channel 0.
    step(0, 1, 0, MODE_SR, 8'h00, 8'h00); chk("sr00_q0", {31'b0, q[0]}, 32'd0);
    step(0, 1, 0, MODE_SR, 8'h00, 8'h01); chk("sr01_q0", {31'b0, q[0]}, 32'd0);
    step(0, 1, 0, MODE_SR, 8'h01, 8'h00); chk("sr10_q0", {31'b0, q[0]}, 32'd1);
    step(0, 1, 0, MODE_SR, 8'h01, 8'h01); chk("sr11_q0", {31'b0, q[0]}, 32'd1);
    chk("sr11_err0", {31'b0, err[0]}, 32'd1);
    step(0, 1, 0, MODE_SR, 8'h00, 8'h00); chk("sr_sticky", {31'b0, err[0]}, 32'd1);
    step(0, 0, 1, MODE_SR, 8'h00, 8'h00); chk("clr_err0", {31'b0, err[0]}, 32'd0);

    // JK toggling from zero; five edges also saturate the 2-bit counter.
    step(1, 1, 0, MODE_JK, 8'h00, 8'h00);
    step(0, 1, 0, MODE_JK, 8'hFF, 8'hFF); chk("jk1", {24'b0, q}, 32'hFF);
    step(0, 1, 0, MODE_JK, 8'hFF, 8'hFF); chk("jk2", {24'b0, q}, 32'h00);
    step(0, 1, 0, MODE_JK, 8'hFF, 8'hFF); chk("jk3", {24'b0, q}, 32'hFF);
    chk("jk_cnt", {24'b0, chg_cnt}, 32'd3);
    step(0, 1, 0, MODE_JK, 8'hFF, 8'hFF);
    step(0, 1, 0, MODE_JK, 8'hFF, 8'hFF);
    chk("sat_cnt", {30'b0, chg_cnt2}, 32'd3);
    chk("nosat_cnt", {24'b0, chg_cnt}, 32'd5);

    // D, T and enable hold.
    step(0, 1, 0, MODE_D, 8'hA5, 8'h00); chk("d_a5", {24'b0, q}, 32'hA5);
    step(0, 1, 0, MODE_T, 8'h0F, 8'h00); chk("t_0f", {24'b0, q}, 32'hAA);
    step(0, 0, 0, MODE_D, 8'hFF, 8'h00); chk("en0_q", {24'b0, q}, 32'hAA);

    // Set wins over a same-edge clear on channel 3.
    step(0, 1, 1, MODE_SR, 8'h08, 8'h08); chk("setwins", {31'b0, err[3]}, 32'd1);

    // Reset in the middle of T-mode toggling with an error pending.
    step(0, 1, 0, MODE_T, 8'hFF, 8'h00);
    step(1, 1, 1, MODE_T, 8'hFF, 8'h00);
    chk("midrst_q", {24'b0, q}, 32'h00);
    chk("midrst_err", {31'b0, err_any}, 32'd0);
    step(0, 1, 0, MODE_T, 8'h81, 8'h00); chk("post_rst", {24'b0, q}, 32'h81);

    // Random mix of modes, enables, clears and occasional resets.
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom));
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
